// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle alert controller.
package obstacle_pkg;

    typedef enum logic [1:0] {
        OBS_IDLE   = 2'd0,
        OBS_ACTIVE = 2'd1,
        OBS_HOLD   = 2'd2
    } obs_state_t;

    localparam logic [1:0] BUZZ_OFF  = 2'b00;
    localparam logic [1:0] BUZZ_ALL  = 2'b01;
    localparam logic [1:0] BUZZ_NEAR = 2'b10;

    // Bits needed for a counter spanning 0..range-1, never less than one.
    function automatic int unsigned ctr_width(input int unsigned range);
        return (range <= 1) ? 1 : 32'($clog2(range));
    endfunction

endpackage

// File: rtl/obstacle_channel.sv
// One sensor channel: input sampling register, debounce filter and
// hold-after-clear state machine.
module obstacle_channel
    import obstacle_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HOLD     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic near,
    output logic close
);

    localparam int unsigned CNT_W  = ctr_width(DEBOUNCE);
    localparam int unsigned HCNT_W = ctr_width(HOLD);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLD - 1);

    logic              sensor_q;
    logic              near_q, near_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    obs_state_t        state_q, state_d;

    // Accept a new level only after it persists for DEBOUNCE sampled cycles.
    always_comb begin
        near_d = near_q;
        cnt_d  = '0;
        if (sensor_q != near_q) begin
            if (cnt_q == CNT_LAST) begin
                near_d = sensor_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sensor_q <= 1'b0;
            near_q   <= 1'b0;
            cnt_q    <= '0;
            state_q  <= OBS_IDLE;
            hcnt_q   <= '0;
        end else begin
            sensor_q <= sensor;
            near_q   <= near_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
        end
    end

    // Re-detection in HOLD wins over hold expiry.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            OBS_IDLE: begin
                if (near_q) state_d = OBS_ACTIVE;
            end
            OBS_ACTIVE: begin
                if (!near_q) begin
                    state_d = OBS_HOLD;
                    hcnt_d  = HCNT_LOAD;
                end
            end
            OBS_HOLD: begin
                if (near_q) begin
                    state_d = OBS_ACTIVE;
                end else if (hcnt_q == '0) begin
                    state_d = OBS_IDLE;
                end else begin
                    hcnt_d = hcnt_q - HCNT_W'(1);
                end
            end
            default: state_d = OBS_IDLE;
        endcase
    end

    always_comb begin
        close = (state_q != OBS_IDLE);
        near  = near_q;
    end

endmodule

// File: rtl/obstacle_alert.sv
// Multi-channel obstacle alert: per-channel filtering/hold, mirrored buzzer
// mapping and all-close code. OBSTACLE_ALERT_BEEP_EN makes code 10 blink.
module obstacle_alert
    import obstacle_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned HOLD      = 8,
    parameter int unsigned BEEP_HALF = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     sensor,
    output logic [NUM_CH-1:0]     near,
    output logic [2*NUM_CH-1:0]   buzz,
    output logic                  any_near
);

    logic [NUM_CH-1:0]   close;
    logic [2*NUM_CH-1:0] mirror_code;
    logic [2*NUM_CH-1:0] buzz_d, buzz_q;
    logic                beep_on;

    if (NUM_CH < 2 || DEBOUNCE < 1 || HOLD < 1 || BEEP_HALF < 1) begin : g_param_check
        $error("obstacle_alert: illegal parameter value");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        obstacle_channel #(
            .DEBOUNCE (DEBOUNCE),
            .HOLD     (HOLD)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .sensor (sensor[i]),
            .near   (near[i]),
            .close  (close[i])
        );
    end

`ifdef OBSTACLE_ALERT_BEEP_EN
    localparam int unsigned BEEP_W = ctr_width(BEEP_HALF);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);

    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              phase_q, phase_d;

    always_comb begin
        beep_cnt_d = beep_cnt_q + BEEP_W'(1);
        phase_d    = phase_q;
        if (beep_cnt_q == BEEP_LAST) begin
            beep_cnt_d = '0;
            phase_d    = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beep_cnt_q <= '0;
            phase_q    <= 1'b1;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            phase_q    <= phase_d;
        end
    end

    assign beep_on = phase_q;
`else
    assign beep_on = 1'b1;
`endif

    // A close channel lights the buzzer on the opposite side.
    for (genvar j = 0; j < NUM_CH; j++) begin : g_map
        assign mirror_code[2*j +: 2] = (close[NUM_CH-1-j] && beep_on) ? BUZZ_NEAR : BUZZ_OFF;
    end

    always_comb begin
        buzz_d = '0;
        if (enable) begin
            buzz_d = (&close) ? {NUM_CH{BUZZ_ALL}} : mirror_code;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buzz_q <= '0;
        end else begin
            buzz_q <= buzz_d;
        end
    end

    assign buzz     = buzz_q;
    assign any_near = |close;

endmodule

// File: tb/tb_obstacle_alert.sv
// Directed bench for obstacle_alert (default parameters, beep disabled):
// expected outputs per cycle are queued and checked after each clock edge.
module tb_obstacle_alert;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] sensor;
    logic [1:0] near;
    logic [3:0] buzz;
    logic       any_near;

    typedef struct {
        logic [1:0] near;
        logic       any;
        logic [3:0] buzz;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    obstacle_alert #(
        .NUM_CH    (2),
        .DEBOUNCE  (4),
        .HOLD      (8),
        .BEEP_HALF (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sensor   (sensor),
        .near     (near),
        .buzz     (buzz),
        .any_near (any_near)
    );

    always #5 clk = ~clk;

    // Drive inputs, queue n identical expectations, then check one per edge.
    task automatic run(input int n, input logic [1:0] s, input logic en, input logic rst,
                       input logic [1:0] e_near, input logic e_any, input logic [3:0] e_buzz,
                       input string tag);
        sensor = s;
        enable = en;
        reset  = rst;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{near: e_near, any: e_any, buzz: e_buzz, tag: tag});
        end
        for (int i = 0; i < n; i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_cmp++;
            assert (near === e.near) else begin
                n_err++;
                $error("FAIL %s[%0d] near observed=%b expected=%b", e.tag, i, near, e.near);
            end
            n_cmp++;
            assert (any_near === e.any) else begin
                n_err++;
                $error("FAIL %s[%0d] any_near observed=%b expected=%b", e.tag, i, any_near, e.any);
            end
            n_cmp++;
            assert (buzz === e.buzz) else begin
                n_err++;
                $error("FAIL %s[%0d] buzz observed=%b expected=%b", e.tag, i, buzz, e.buzz);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        sensor = 2'b00;

        run(2, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 4'b0000, "reset");
        run(4, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, "idle");

        // Left sensor: near at edge 5, ACTIVE at 6, buzzer 1 at 7.
        run(4, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, "left_wait");
        run(1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 4'b0000, "left_near");
        run(1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4'b0000, "left_active");
        run(3, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000, "left_buzz");

        // Release: near falls at 5, IDLE at 14, buzz clears at 15.
        run(4, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000, "rel_wait");
        run(9, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 4'b1000, "rel_hold");
        run(1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 4'b1000, "rel_idle");
        run(2, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, "rel_off");

        run(3, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, "glitch_pulse");
        run(6, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, "glitch_after");

        // Both rise together: straight to 0101 with no intermediate 10.
        run(4, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, "both_wait");
        run(1, 2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 4'b0000, "both_near");
        run(1, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0000, "both_active");
        run(3, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0101, "both_all");

        // Drop right: 0101 persists through hold, then 1000.
        run(4,  2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 4'b0101, "drop_wait");
        run(10, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4'b0101, "drop_hold");
        run(2,  2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000, "drop_done");

        // Left clears, enters HOLD, then re-asserts before expiry.
        run(4, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000, "hold_wait");
        run(2, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 4'b1000, "hold_in");
        run(4, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 4'b1000, "retrig_wait");
        run(8, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000, "retrig_active");

        run(3, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 4'b0000, "disable");
        run(2, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000, "reenable");

        // Reset mid-operation discards state; detection restarts from scratch.
        run(1, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 4'b0000, "mid_reset");
        run(4, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 4'b0000, "post_rst_wait");
        run(1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 4'b0000, "post_rst_near");
        run(1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4'b0000, "post_rst_active");
        run(2, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 4'b1000, "post_rst_buzz");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
